// File: rtl/ay_pkg.sv
// Shared types and helpers for the AY-3-8500 paddle controller.
// Holds the channel state encoding and the saturating position step.
package ay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        FIRED
    } paddle_state_t;

    localparam int POS_W = 9;

    // One extra bit catches borrow on decrement and overshoot on increment.
    function automatic logic [POS_W-1:0] sat_step(
        input logic [POS_W-1:0] pos,
        input logic [POS_W-1:0] step,
        input logic             dec,
        input logic [POS_W-1:0] pmax
    );
        logic [POS_W:0] sum;
        if (dec) begin
            sum = {1'b0, pos} - {1'b0, step};
            sat_step = sum[POS_W] ? '0 : sum[POS_W-1:0];
        end else begin
            sum = {1'b0, pos} + {1'b0, step};
            sat_step = (sum > {1'b0, pmax}) ? pmax : sum[POS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/ay_paddle_channel.sv
// One player channel: source select, position register,
// line counter and the pin-sequencing state machine.
module ay_paddle_channel
    import ay_pkg::*;
#(
    parameter int POS_MAX    = 255,
    parameter int POS_CENTER = 128,
    parameter int STEP_SLOW  = 5,
    parameter int STEP_FAST  = 8,
    parameter int DEADZONE   = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             vs_ev,
    input  logic             hs_ev,
    input  logic             fast,
    input  logic             analog_en,
    input  logic             up,
    input  logic             down,
    input  logic [7:0]       ana_y,
    output logic             pin,
    output logic [POS_W-1:0] pos
);

    paddle_state_t    state, state_d;
    logic [POS_W-1:0] cnt, cnt_d;
    logic [POS_W-1:0] pos_d;
    logic             pin_d;
    logic [7:0]       y_abs;
    logic [9:0]       ana_sum;
    logic [POS_W-1:0] step;
    logic             use_ana;

    // Magnitude of -128 is 128, which still fits the unsigned byte.
    assign y_abs   = ana_y[7] ? 8'(-ana_y) : ana_y;
    assign use_ana = analog_en && (y_abs >= 8'(DEADZONE));
    assign ana_sum = 10'(POS_CENTER) + {{2{ana_y[7]}}, ana_y};
    assign step    = fast ? POS_W'(STEP_FAST) : POS_W'(STEP_SLOW);

    always_comb begin
        pos_d = pos;
        if (vs_ev) begin
            if (use_ana) begin
                if (ana_sum[9])
                    pos_d = '0;
                else if (ana_sum > 10'(POS_MAX))
                    pos_d = POS_W'(POS_MAX);
                else
                    pos_d = ana_sum[POS_W-1:0];
            end else if (up && !down) begin
                pos_d = sat_step(pos, step, 1'b1, POS_W'(POS_MAX));
            end else if (down && !up) begin
                pos_d = sat_step(pos, step, 1'b0, POS_W'(POS_MAX));
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pos   <= POS_W'(POS_CENTER);
            pin   <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            pos   <= pos_d;
            pin   <= pin_d;
        end
    end

    // The old position is latched here; pos_d lands a frame later.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (1'b1)
            vs_ev: begin
                cnt_d   = pos;
                state_d = (pos == '0) ? FIRED : COUNT;
            end
            hs_ev && (state == COUNT): begin
                cnt_d = cnt - POS_W'(1);
                if (cnt == POS_W'(1))
                    state_d = FIRED;
            end
            default: ;
        endcase
    end

    always_comb begin
        pin_d = (state_d != COUNT);
    end

endmodule

// File: rtl/ay_paddle_ctrl.sv
// Frame-synchronous paddle controller: sync registers, edge detect
// and the frame tick, feeding one channel per player.
module ay_paddle_ctrl
    import ay_pkg::*;
#(
    parameter int POS_MAX    = 255,
    parameter int POS_CENTER = 128,
    parameter int STEP_SLOW  = 5,
    parameter int STEP_FAST  = 8,
    parameter int DEADZONE   = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       sync_h_n,
    input  logic       sync_v_n,
    input  logic       fast,
    input  logic       analog_en,
    input  logic [1:0] up,
    input  logic [1:0] down,
    input  logic [7:0] ana_y0,
    input  logic [7:0] ana_y1,
    output logic       lp_in,
    output logic       rp_in,
    output logic [8:0] pos0,
    output logic [8:0] pos1,
    output logic       frame_tick
);

    logic sv_q, sh_q;
    logic vs_ev, hs_ev;
    logic vs_fall, hs_fall;

    assign vs_fall = sv_q & ~sync_v_n;
    assign hs_fall = sh_q & ~sync_h_n;

    // A coincident hsync edge is dropped so the fresh load is not decremented.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            sv_q       <= 1'b1;
            sh_q       <= 1'b1;
            vs_ev      <= 1'b0;
            hs_ev      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sv_q       <= sync_v_n;
            sh_q       <= sync_h_n;
            vs_ev      <= vs_fall;
            hs_ev      <= hs_fall & ~vs_fall;
            frame_tick <= vs_ev;
        end
    end

    ay_paddle_channel #(
        .POS_MAX    (POS_MAX),
        .POS_CENTER (POS_CENTER),
        .STEP_SLOW  (STEP_SLOW),
        .STEP_FAST  (STEP_FAST),
        .DEADZONE   (DEADZONE)
    ) u_ch0 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vs_ev     (vs_ev),
        .hs_ev     (hs_ev),
        .fast      (fast),
        .analog_en (analog_en),
        .up        (up[0]),
        .down      (down[0]),
        .ana_y     (ana_y0),
        .pin       (lp_in),
        .pos       (pos0)
    );

    ay_paddle_channel #(
        .POS_MAX    (POS_MAX),
        .POS_CENTER (POS_CENTER),
        .STEP_SLOW  (STEP_SLOW),
        .STEP_FAST  (STEP_FAST),
        .DEADZONE   (DEADZONE)
    ) u_ch1 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vs_ev     (vs_ev),
        .hs_ev     (hs_ev),
        .fast      (fast),
        .analog_en (analog_en),
        .up        (up[1]),
        .down      (down[1]),
        .ana_y     (ana_y1),
        .pin       (rp_in),
        .pos       (pos1)
    );

endmodule

// File: tb/tb_ay_paddle_ctrl.sv
// Scoreboard bench for ay_paddle_ctrl: frames of 3-cycle lines,
// expected positions and pin-low lengths come from a frame-level model.
module tb_ay_paddle_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b0;
    logic       sync_h_n = 1'b1;
    logic       sync_v_n = 1'b1;
    logic       fast = 1'b0;
    logic       analog_en = 1'b0;
    logic [1:0] up = '0;
    logic [1:0] down = '0;
    logic [7:0] ana_y0 = '0;
    logic [7:0] ana_y1 = '0;
    logic       lp_in, rp_in;
    logic [8:0] pos0, pos1;
    logic       frame_tick;

    ay_paddle_ctrl dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .sync_h_n   (sync_h_n),
        .sync_v_n   (sync_v_n),
        .fast       (fast),
        .analog_en  (analog_en),
        .up         (up),
        .down       (down),
        .ana_y0     (ana_y0),
        .ana_y1     (ana_y1),
        .lp_in      (lp_in),
        .rp_in      (rp_in),
        .pos0       (pos0),
        .pos1       (pos1),
        .frame_tick (frame_tick)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int p0;
        int p1;
        int low0;
        int low1;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   mp0 = 128;
    int   mp1 = 128;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model(int p, bit ae, int y, bit f, bit u, bit d);
        int a;
        int v;
        a = (y < 0) ? -y : y;
        if (ae && a >= 8) begin
            v = 128 + y;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            return v;
        end
        if (u && !d) begin
            v = p - (f ? 8 : 5);
            return (v < 0) ? 0 : v;
        end
        if (d && !u) begin
            v = p + (f ? 8 : 5);
            return (v > 255) ? 255 : v;
        end
        return p;
    endfunction

    // Line k's hsync falls at cycle 3k; optionally also at cycle 0 with vsync.
    task automatic frame(input int L, input bit hs0, input bit f,
                         input bit ae, input int y0, input int y1,
                         input bit [1:0] u, input bit [1:0] d);
        exp_t e;
        @(posedge clk_sys);
        #1;
        fast      = f;
        analog_en = ae;
        ana_y0    = y0[7:0];
        ana_y1    = y1[7:0];
        up        = u;
        down      = d;
        e.low0 = 3 * ((mp0 < L) ? mp0 : L);
        e.low1 = 3 * ((mp1 < L) ? mp1 : L);
        mp0 = model(mp0, ae, y0, f, u[0], d[0]);
        mp1 = model(mp1, ae, y1, f, u[1], d[1]);
        e.p0 = mp0;
        e.p1 = mp1;
        if (mon_en) sbq.push_back(e);
        for (int c = 0; c < 3 * L; c++) begin
            if (c > 0) begin
                @(posedge clk_sys);
                #1;
            end
            sync_v_n = (c != 0);
            sync_h_n = !((c % 3 == 0) && (c != 0 || hs0));
        end
    endtask

    initial begin : monitor
        exp_t cur;
        bit   have;
        int   c0;
        int   c1;
        have = 1'b0;
        c0 = 0;
        c1 = 0;
        forever begin
            @(negedge clk_sys);
            if (!mon_en) begin
                have = 1'b0;
            end else begin
                if (frame_tick) begin
                    if (have) begin
                        chk("lp_low_cycles", c0, cur.low0);
                        chk("rp_low_cycles", c1, cur.low1);
                    end
                    if (sbq.size() == 0) begin
                        chk("unexpected_tick", 1, 0);
                        have = 1'b0;
                    end else begin
                        cur  = sbq.pop_front();
                        have = 1'b1;
                        chk("pos0", int'(pos0), cur.p0);
                        chk("pos1", int'(pos1), cur.p1);
                    end
                    c0 = 0;
                    c1 = 0;
                end
                if (!lp_in) c0++;
                if (!rp_in) c1++;
            end
        end
    end

    initial begin : stim
        int L;
        int y0;
        int y1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_pos0", int'(pos0), 128);
        chk("rst_pos1", int'(pos1), 128);
        chk("rst_lp", int'(lp_in), 1);
        chk("rst_rp", int'(rp_in), 1);
        chk("rst_tick", int'(frame_tick), 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        repeat (3) frame(260, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        repeat (30) frame(260, 0, 0, 0, 0, 0, 2'b01, 2'b10);
        repeat (4) frame(120, 0, 1, 0, 0, 0, 2'b00, 2'b01);
        repeat (5) frame(120, 0, 1, 0, 0, 0, 2'b11, 2'b11);

        frame(260, 0, 0, 1, 127, -128, 2'b00, 2'b00);
        frame(260, 0, 0, 1, -128, 127, 2'b00, 2'b00);
        frame(260, 0, 0, 1, 5, -7, 2'b01, 2'b01);
        frame(260, 1, 0, 1, -8, 8, 2'b00, 2'b00);
        frame(260, 1, 0, 1, 7, 100, 2'b10, 2'b01);

        // Short frames: the counter is reloaded before it expires.
        frame(40, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        frame(40, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        frame(200, 1, 0, 0, 0, 0, 2'b00, 2'b00);

        repeat (30) begin
            L  = $urandom_range(20, 260);
            y0 = int'($urandom_range(0, 255)) - 128;
            y1 = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 3) == 0) y0 = int'($urandom_range(0, 16)) - 8;
            frame(L, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), y0, y1,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        frame(260, 0, 0, 1, 20, 20, 2'b00, 2'b00);
        frame(260, 0, 0, 1, 20, 20, 2'b00, 2'b00);
        @(negedge clk_sys);
        mon_en = 1'b0;
        chk("sb_drained", sbq.size(), 0);

        @(posedge clk_sys);
        #1 sync_v_n = 1'b0;
        @(posedge clk_sys);
        #1 sync_v_n = 1'b1;
        repeat (20) @(posedge clk_sys);
        #2;
        chk("mid_count_lp", int'(lp_in), 0);
        chk("mid_count_rp", int'(rp_in), 0);
        reset = 1'b0;
        #1;
        chk("async_rst_lp", int'(lp_in), 1);
        chk("async_rst_rp", int'(rp_in), 1);
        chk("async_rst_pos0", int'(pos0), 128);
        chk("async_rst_pos1", int'(pos1), 128);
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("post_rst_pos0", int'(pos0), 128);
        chk("post_rst_lp", int'(lp_in), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ay_paddle_ctrl.md
# ay_paddle_ctrl

Frame-synchronous paddle controller for the AY-3-8500 core. It converts per-player digital up/down buttons or analog joystick Y into a paddle position. It then sequences the chip's LPin/RPin ramp inputs once per video frame, timed from the chip's own sync outputs. It sits between hps_io/keyboard decode and the `ay38500NTSC` instance and replaces the ad-hoc capacitor-countdown logic in the top level.

## Interface
Parameters:
- `POS_MAX`, 255: largest paddle position, in scanlines after vsync.
- `POS_CENTER`, 128: position after reset.
- `STEP_SLOW`, 5: digital step per frame when `fast`=0.
- `STEP_FAST`, 8: digital step per frame when `fast`=1.
- `DEADZONE`, 8: analog magnitude below which the stick is ignored.

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low.
- `sync_h_n` in 1: chip horizontal sync, active-low.
- `sync_v_n` in 1: chip vertical sync, active-low.
- `fast` in 1: selects `STEP_FAST`.
- `analog_en` in 1: enables the analog source.
- `up` in 2: up button; bit0 = P1, bit1 = P2.
- `down` in 2: down button; bit0 = P1, bit1 = P2.
- `ana_y0` in 8: P1 stick Y, signed two's complement.
- `ana_y1` in 8: P2 stick Y, signed two's complement.
- `lp_in` out 1: drives chip pinLPin.
- `rp_in` out 1: drives chip pinRPin.
- `pos0` out 9: current P1 position, for debug/OSD.
- `pos1` out 9: current P2 position, for debug/OSD.
- `frame_tick` out 1: one-cycle pulse on each detected vsync edge.

## Operation
- Sync inputs are registered once; edges are detected against the registered copy.
  - The vsync edge is the falling edge of `sync_v_n`.
  - The hsync edge is the falling edge of `sync_h_n`.
- Each player channel runs its own state machine (IDLE, COUNT, FIRED), driven by the edge events:
  - IDLE → COUNT on a vsync edge: latch `pos` into the 9-bit counter `cnt`. If the latched `pos` is 0, go straight to FIRED instead.
  - COUNT: on each hsync edge, `cnt` decrements by 1. When `cnt` reaches 0 → FIRED.
  - FIRED → COUNT (or → FIRED if `pos`=0) on the next vsync edge, with a fresh latch.
  - Pin output is 1 in IDLE and FIRED, 0 in COUNT.
- A vsync edge and an hsync edge in the same cycle: vsync wins and the hsync edge is discarded.
- Position update happens on the vsync edge, after the old `pos` has been latched into `cnt`. The new position therefore takes effect on the following frame.
- Analog source is selected when `analog_en`=1 and |ana_y| ≥ `DEADZONE`:
  - `pos` = clamp(`POS_CENTER` + ana_y, 0, `POS_MAX`).
  - Compute the sum 10-bit signed.
  - Use −128 as-is; do not saturate it to −127.
- Digital source is used otherwise:
  - `up` alone: `pos` = max(`pos` − step, 0).
  - `down` alone: `pos` = min(`pos` + step, `POS_MAX`).
  - Both or neither pressed: `pos` holds.
  - Saturation is exact; `pos` never wraps or exceeds `POS_MAX`.
- Switching `analog_en` or `fast` mid-frame takes effect at the next vsync edge. Inputs are sampled only on that cycle.

## Timing
- Reset (async assert, sync release):
  - state IDLE, `cnt`=0, `pos0`=`pos1`=`POS_CENTER`.
  - `lp_in`=`rp_in`=1, `frame_tick`=0.
- Reset asserted mid-COUNT forces the outputs above immediately, without waiting for a clock edge.
- Edge-to-output latency:
  - `sync_*_n` transition → registered edge → state/pin update on the next edge. Total 2 `clk_sys` cycles.
  - `frame_tick` follows the same 2-cycle path.
- Pin low duration equals the latched `pos` hsync edges, counted from the vsync edge.
  - `pos`=0 gives zero low cycles.
  - `POS_MAX` gives 255 hsync periods.
- If a new vsync arrives while still in COUNT (frame shorter than `pos` lines), the counter is reloaded; the pin stays 0 until it expires.
- Outputs are glitch-free: all outputs are driven directly from flops.

## Structure
- Package `ay_pkg`:
  - `paddle_state_t` enum {IDLE, COUNT, FIRED}.
  - Localparams for the position width (9).
  - The saturating add/sub function.
- Sub-module `ay_paddle_channel`, instantiated twice. It contains the source select, the position register, the counter and the FSM.
- Top `ay_paddle_ctrl` holds only the sync registers, the edge detect and the `frame_tick` output.

## Test plan
- **Reset:** release reset, then 3 frames with no input → `pos0`=128. `lp_in` is low for exactly 128 hsync edges after each vsync, then high.
- **Digital saturation:** hold P1 `up` with `fast`=0 for 30 frames → `pos0` sequence 123, 118, …, 3, then 0 and held. Holding `down` climbs to 255 and never wraps.
- **Speed and conflict:** `fast`=1, press `down` once per frame → `pos0` steps by 8. `up`+`down` together for 5 frames → `pos0` unchanged.
- **Analog:** `analog_en`=1.
  - ana_y0 = +127 → `pos0`=255.
  - ana_y0 = −128 → `pos0`=0; `lp_in` is high from 2 cycles after the vsync edge.
  - ana_y0 = 5 (inside the deadzone) → the digital path is used.
- **Simultaneous and short frame:** vsync and hsync edges in the same cycle → counter loaded, no decrement. A vsync arriving at `cnt`=40 → reload, and `rp_in` stays 0.
- **Reset mid-operation:** assert `reset` mid-COUNT → `lp_in`=1 with no clock edge required. After release, `pos`=128.
